// File: rtl/data_ram_responder.sv
// data_ram_responder: CPU data memory. After reset it zeroes the whole array
// (INIT) and then serves single-cycle loads and stores (READY). Out-of-range
// requests are dropped and latched into a sticky addr_error flag.
module data_ram_responder #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ram_enable_read,
    input  logic                 ram_enable_write,
    input  logic [WORD_SIZE-1:0] ram_address,
    input  logic [WORD_SIZE-1:0] ram_data_write,
    output logic [WORD_SIZE-1:0] ram_data_read,
    output logic                 ready,
    output logic                 addr_error
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [ADDR_BITS-1:0]   ptr_r;
    logic [ADDR_BITS-1:0]   ptr_next_s;
    logic [WORD_SIZE-1:0]   mem_r [DEPTH];
    logic [WORD_SIZE-1:0]   data_read_r;
    logic                   ready_r;
    logic                   addr_error_r;

    logic                   in_range_s;
    logic [ADDR_BITS-1:0]   index_s;
    logic                   serving_s;
    logic                   load_s;
    logic                   store_s;
    logic                   bad_req_s;
    logic                   mem_we_s;
    logic [ADDR_BITS-1:0]   mem_wa_s;
    logic [WORD_SIZE-1:0]   mem_wd_s;
    logic [WORD_SIZE-1:0]   load_value_s;

    // Address is in range only when every bit above the storage index is zero,
    // so wide addresses are rejected rather than aliased onto low words.
    function automatic logic addr_in_range(input logic [WORD_SIZE-1:0] addr);
        return (addr[WORD_SIZE-1:ADDR_BITS] == {(WORD_SIZE-ADDR_BITS){1'b0}});
    endfunction

    // Request decode: which of load/store/error apply this cycle.
    always_comb begin
        in_range_s = addr_in_range(ram_address);
        index_s    = ram_address[ADDR_BITS-1:0];
        serving_s  = (state_r == ST_READY);
        load_s     = serving_s & ram_enable_read;
        store_s    = serving_s & ram_enable_write & in_range_s;
        bad_req_s  = serving_s & (ram_enable_read | ram_enable_write) & ~in_range_s;
    end

    // Load data selection: out-of-range gives zero, a same-cycle store to the
    // same word is forwarded (write-first), otherwise the stored word.
    always_comb begin
        load_value_s = {WORD_SIZE{1'b0}};
        if (!in_range_s) begin
            load_value_s = {WORD_SIZE{1'b0}};
        end else if (store_s) begin
            load_value_s = ram_data_write;
        end else begin
            load_value_s = mem_r[index_s];
        end
    end

    // Single array write port: clearing sweep during INIT, CPU stores in READY.
    always_comb begin
        mem_we_s = 1'b0;
        mem_wa_s = {ADDR_BITS{1'b0}};
        mem_wd_s = {WORD_SIZE{1'b0}};
        if (state_r == ST_INIT) begin
            mem_we_s = 1'b1;
            mem_wa_s = ptr_r;
            mem_wd_s = {WORD_SIZE{1'b0}};
        end else begin
            mem_we_s = store_s;
            mem_wa_s = index_s;
            mem_wd_s = ram_data_write;
        end
    end

    // FSM next state: sweep the pointer through every word, then serve forever.
    always_comb begin
        state_next_s = state_r;
        ptr_next_s   = ptr_r;
        case (state_r)
            ST_INIT: begin
                ptr_next_s = ptr_r + {{(ADDR_BITS-1){1'b0}}, 1'b1};
                if (ptr_r == {ADDR_BITS{1'b1}}) begin
                    state_next_s = ST_READY;
                end else begin
                    state_next_s = ST_INIT;
                end
            end
            ST_READY: begin
                state_next_s = ST_READY;
                ptr_next_s   = ptr_r;
            end
            default: begin
                state_next_s = ST_INIT;
                ptr_next_s   = {ADDR_BITS{1'b0}};
            end
        endcase
    end

    // FSM state and clear-pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_INIT;
            ptr_r   <= {ADDR_BITS{1'b0}};
        end else begin
            state_r <= state_next_s;
            ptr_r   <= ptr_next_s;
        end
    end

    // Storage array; contents are cleared by the INIT sweep, not by reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_wa_s] <= mem_wd_s;
        end
    end

    // Registered outputs: load data held until the next load, sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_read_r  <= {WORD_SIZE{1'b0}};
            ready_r      <= 1'b0;
            addr_error_r <= 1'b0;
        end else begin
            ready_r <= (state_next_s == ST_READY);
            if (load_s) begin
                data_read_r <= load_value_s;
            end
            if (bad_req_s) begin
                addr_error_r <= 1'b1;
            end
        end
    end

    assign ram_data_read = data_read_r;
    assign ready         = ready_r;
    assign addr_error    = addr_error_r;

endmodule
